// File: rtl/upstream_port_sink.sv
// Sink endpoint for one switch upstream port: parses header/payload/checksum
// frames and forwards only checksum-verified payload. Optional counters: UPSTREAM_SINK_STATS_EN.
module upstream_port_sink #(
  parameter int DEPTH   = 64,
  parameter int MAX_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        up_valid,
  input  logic [7:0]  up_data,
  output logic        up_ready,
  output logic        pkt_valid,
  output logic [7:0]  pkt_data,
  output logic        pkt_last,
  input  logic        pkt_ready,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] pkt_cnt,
  output logic [15:0] err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    S_HDR  = 2'd0,
    S_PAY  = 2'd1,
    S_CSUM = 2'd2,
    S_DROP = 2'd3
  } state_e;

  localparam logic [1:0] ERR_LEN_ZERO = 2'b01;
  localparam logic [1:0] ERR_LEN_BIG  = 2'b10;
  localparam logic [1:0] ERR_CSUM     = 2'b11;

  state_e         r_state;
  state_e         w_state_nxt;
  logic [8:0]     r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_commit_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW-1:0]  w_free;
  logic [7:0]     r_rem;
  logic [7:0]     r_csum;
  logic [8:0]     r_drop_cnt;
  logic           r_err;
  logic [1:0]     r_err_code;
  logic [8:0]     w_rd_entry;

  logic           w_up_ready;
  logic           w_up_beat;
  logic           w_rd_beat;
  logic           w_wr_en;
  logic           w_commit;
  logic           w_rollback;
  logic           w_err_set;
  logic [1:0]     w_err_code_nxt;
  logic           w_len_zero;
  logic           w_len_big;

  // free is based on the registered rd_ptr, so a read frees space one cycle later
  assign w_free     = PW'(DEPTH) - (r_wr_ptr - r_rd_ptr);
  assign w_len_zero = (up_data == 8'd0);
  assign w_len_big  = ({1'b0, up_data} > 9'(MAX_LEN));

  // Ready depends only on state and occupancy, never on up_valid.
  always_comb begin
    w_up_ready = 1'b1;
    if (r_state == S_PAY) w_up_ready = (w_free != '0);
  end

  assign up_ready  = reset & w_up_ready;
  assign w_up_beat = up_valid & up_ready;

  assign w_rd_entry = r_mem[r_rd_ptr[AW-1:0]];
  assign pkt_valid  = (r_commit_ptr != r_rd_ptr);
  assign pkt_data   = pkt_valid ? w_rd_entry[7:0] : 8'h00;
  assign pkt_last   = pkt_valid & w_rd_entry[8];
  assign w_rd_beat  = pkt_valid & pkt_ready;

  assign err      = r_err;
  assign err_code = r_err_code;

  // NOTE: sequential state uses <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_HDR;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default first, so no branch can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_wr_en        = 1'b0;
    w_commit       = 1'b0;
    w_rollback     = 1'b0;
    w_err_set      = 1'b0;
    w_err_code_nxt = r_err_code;
    case (r_state)
      S_HDR: begin
        if (w_up_beat) begin
          if (w_len_zero) begin
            w_err_set      = 1'b1;
            w_err_code_nxt = ERR_LEN_ZERO;
          end else if (w_len_big) begin
            w_err_set      = 1'b1;
            w_err_code_nxt = ERR_LEN_BIG;
            w_state_nxt    = S_DROP;
          end else begin
            w_state_nxt = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (w_up_beat) begin
          w_wr_en = 1'b1;
          if (r_rem == 8'd1) w_state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (w_up_beat) begin
          if (up_data == r_csum) begin
            w_commit = 1'b1;
          end else begin
            w_rollback     = 1'b1;
            w_err_set      = 1'b1;
            w_err_code_nxt = ERR_CSUM;
          end
          w_state_nxt = S_HDR;
        end
      end
      S_DROP: begin
        if (w_up_beat && r_drop_cnt == 9'd1) w_state_nxt = S_HDR;
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  // NOTE: the payload RAM is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {(r_rem == 8'd1), up_data};
  end

  // Rollback only rewinds wr_ptr to commit_ptr, which never lies behind rd_ptr.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_rd_ptr     <= '0;
    end else begin
      if (w_wr_en)         r_wr_ptr <= r_wr_ptr + 1'b1;
      else if (w_rollback) r_wr_ptr <= r_commit_ptr;
      if (w_commit)  r_commit_ptr <= r_wr_ptr;
      if (w_rd_beat) r_rd_ptr     <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem      <= '0;
      r_csum     <= '0;
      r_drop_cnt <= '0;
    end else if (w_up_beat) begin
      case (r_state)
        S_HDR: begin
          r_rem      <= up_data;
          r_csum     <= up_data;
          r_drop_cnt <= {1'b0, up_data} + 9'd1;
        end
        S_PAY: begin
          r_rem  <= r_rem - 8'd1;
          r_csum <= r_csum ^ up_data;
        end
        S_DROP:  r_drop_cnt <= r_drop_cnt - 9'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_err      <= w_err_set;
      r_err_code <= w_err_code_nxt;
    end
  end

`ifdef UPSTREAM_SINK_STATS_EN
  logic [15:0] r_pkt_cnt;
  logic [15:0] r_err_cnt;

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pkt_cnt <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_commit && r_pkt_cnt != 16'hFFFF)  r_pkt_cnt <= r_pkt_cnt + 16'd1;
      if (w_err_set && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign pkt_cnt = r_pkt_cnt;
  assign err_cnt = r_err_cnt;
`else
  assign pkt_cnt = 16'h0000;
  assign err_cnt = 16'h0000;
`endif

endmodule
